// File: rtl/xps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 11-bit frame on device clock, check ACK.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out frame once before reporting tx_err.
module xps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state, state_nx;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev, fall;
  logic [9:0]    frame, frame_nx;
  logic [3:0]    bit_cnt, bit_cnt_nx;
  logic [IW-1:0] inh_cnt, inh_cnt_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic          done_nx, err_nx, fail, clk_oe_c, data_oe_c;
`ifdef PS2_TX_RETRY_EN
  logic          retried, retried_nx;
  logic [7:0]    byte_q;
`endif

  assign fall        = clk_prev & ~clk_sync[1];
  assign tx_busy     = (state != IDLE);
  assign rx_inhibit  = tx_busy;
  assign ps2_clk_oe  = clk_oe_c;
  assign ps2_data_oe = data_oe_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
      frame     <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried   <= 1'b0;
      byte_q    <= '0;
`endif
    end else begin
      state     <= state_nx;
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_sync[1];
      frame     <= frame_nx;
      bit_cnt   <= bit_cnt_nx;
      inh_cnt   <= inh_cnt_nx;
      to_cnt    <= to_cnt_nx;
      tx_done   <= done_nx;
      tx_err    <= err_nx;
`ifdef PS2_TX_RETRY_EN
      retried   <= retried_nx;
      if (state == IDLE && tx_start) byte_q <= tx_data;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    frame_nx   = frame;
    bit_cnt_nx = bit_cnt;
    inh_cnt_nx = inh_cnt;
    to_cnt_nx  = to_cnt;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    fail       = 1'b0;
    clk_oe_c   = 1'b0;
    data_oe_c  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retried_nx = retried;
`endif
    case (state)
      IDLE: if (tx_start) begin
        frame_nx   = {1'b1, ~^tx_data, tx_data};
        bit_cnt_nx = '0;
        inh_cnt_nx = '0;
        state_nx   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
        retried_nx = 1'b0;
`endif
      end
      INHIBIT: begin
        clk_oe_c = 1'b1;
        if (inh_cnt == INH_LAST) begin
          data_oe_c = 1'b1;  // start bit goes low before the clock is released
          to_cnt_nx = '0;
          state_nx  = REQ;
        end else begin
          inh_cnt_nx = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        data_oe_c = 1'b1;
        if (fall) begin
          bit_cnt_nx = 4'd1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        // frame[0] is the bit owed for the most recent fall; stop bit leaves the line released
        data_oe_c = ~frame[0];
        if (fall) begin
          frame_nx   = {1'b1, frame[9:1]};
          bit_cnt_nx = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_nx = ACK;
        end
      end
      ACK: if (fall) begin
        if (!data_sync[1]) state_nx = WAIT_IDLE;
        else               fail     = 1'b1;
      end
      WAIT_IDLE: if (clk_sync[1] && data_sync[1]) begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state inside {REQ, SHIFT, ACK, WAIT_IDLE}) begin
      if (to_cnt < TO_MAX) to_cnt_nx = to_cnt + 1'b1;
      if (to_cnt >= TO_LAST) fail = 1'b1;
    end

    if (fail) begin
      done_nx = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        retried_nx = 1'b1;
        frame_nx   = {1'b1, ~^byte_q, byte_q};
        bit_cnt_nx = '0;
        inh_cnt_nx = '0;
        state_nx   = INHIBIT;
      end else begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
`else
      err_nx   = 1'b1;
      state_nx = IDLE;
`endif
    end
  end
endmodule

// File: tb/tb_xps2_tx.sv
// Directed bench for xps2_tx: a behavioural keyboard clocks frames, ACKs/NACKs, or stays silent.
module tb_xps2_tx;
  localparam int INH  = 5000;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0, rst = 1'b0, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_done, tx_err, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  xps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #10 clk = ~clk;

  int checks = 0, passed = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, inh_len = 0, inh_run = 0, req_cyc = 0, err_cyc = 0;
  logic [1:0] err_lines = 2'b11;
  bit   both_seen = 1'b0;
  logic clk_oe_d = 1'b0;
  logic rst_busy;
  logic [1:0] rst_oe;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) begin
      err_cnt++;
      err_cyc   = cyc;
      err_lines = {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done === 1'b1 && tx_err === 1'b1) both_seen = 1'b1;
    if (ps2_clk_oe === 1'b1) inh_run++;
    else if (clk_oe_d === 1'b1) begin
      inh_len = inh_run;
      inh_run = 0;
      req_cyc = cyc;
    end
    clk_oe_d = ps2_clk_oe;
  end

  task automatic do_start(input logic [7:0] b);
    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, clocks 11 falls, reads each bit on the rising edge.
  task automatic device(input bit ack, input int stop_at, input int pulse_at,
                        output logic [10:0] bits, output bit ok);
    int n;
    ok = 1'b0; bits = '0; n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < INH + 1000) begin
      @(negedge clk); n++;
    end
    if (n >= INH + 1000) return;
    ok = 1'b1;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (i == stop_at) begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst_busy = tx_busy;
        rst_oe   = {ps2_clk_oe, ps2_data_oe};
        rst = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
        return;
      end
      if (i == pulse_at) begin
        @(negedge clk); tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = ps2_data_in;
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    ok = (tx_busy === 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_busy, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 6'b0)
      $display("FAIL reset_outputs got %b want 000000",
               {tx_busy, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    else passed++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_check(input string name, input logic [7:0] b, input logic [10:0] exp_bits);
    logic [10:0] bits; bit ok, idle_ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_start(b);
    checks++;
    if (tx_busy !== 1'b1 || rx_inhibit !== 1'b1)
      $display("FAIL %s_busy got busy=%b inh=%b want 1 1", name, tx_busy, rx_inhibit);
    else passed++;
    device(1'b1, 0, 0, bits, ok);
    wait_idle(2000, idle_ok);
    checks++;
    if (!ok || !idle_ok) $display("FAIL %s_timing got req=%0d idle=%0d want 1 1", name, ok, idle_ok);
    else passed++;
    checks++;
    if (bits !== exp_bits) $display("FAIL %s_bits got %b want %b", name, bits, exp_bits);
    else passed++;
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL %s_pulses got done=%0d err=%0d want 1 0", name, done_cnt - d0, err_cnt - e0);
    else passed++;
    checks++;
    if (inh_len !== INH) $display("FAIL %s_inhibit_width got %0d want %0d", name, inh_len, INH);
    else passed++;
  endtask

  task automatic test_send;
    send_check("ed", 8'hED, {1'b1, 1'b1, 8'hED, 1'b0});
  endtask

  task automatic test_parity;
    send_check("f4", 8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0});
    send_check("zero", 8'h00, {1'b1, 1'b1, 8'h00, 1'b0});
  endtask

  task automatic test_nack;
    logic [10:0] bits; bit ok, idle_ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'hF4);
    device(1'b0, 0, 0, bits, ok);
`ifdef PS2_TX_RETRY_EN
    checks++;
    if (err_cnt - e0 !== 0 || tx_busy !== 1'b1)
      $display("FAIL nack_retry got err=%0d busy=%b want 0 1", err_cnt - e0, tx_busy);
    else passed++;
    device(1'b0, 0, 0, bits, ok);
`endif
    wait_idle(2000, idle_ok);
    checks++;
    if (!ok || !idle_ok || err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL nack_pulses got ok=%0d err=%0d done=%0d want 1 1 0",
               ok && idle_ok, err_cnt - e0, done_cnt - d0);
    else passed++;
    checks++;
    if (err_lines !== 2'b00) $display("FAIL nack_release got %b want 00", err_lines);
    else passed++;
  endtask

  task automatic test_timeout;
    bit idle_ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'h00);
    wait_idle(2 * (INH + TO) + 100, idle_ok);
    checks++;
    if (!idle_ok || err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL timeout_pulses got idle=%0d err=%0d done=%0d want 1 1 0",
               idle_ok, err_cnt - e0, done_cnt - d0);
    else passed++;
    checks++;
    if (err_cyc - req_cyc !== TO) $display("FAIL timeout_latency got %0d want %0d", err_cyc - req_cyc, TO);
    else passed++;
    checks++;
    if (err_lines !== 2'b00) $display("FAIL timeout_release got %b want 00", err_lines);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits; bit ok, idle_ok, stayed_idle; int d0;
    d0 = done_cnt;
    do_start(8'hED);
    device(1'b1, 0, 4, bits, ok);
    wait_idle(2000, idle_ok);
    checks++;
    if (!ok || bits !== {1'b1, 1'b1, 8'hED, 1'b0})
      $display("FAIL b2b_bits got %b want %b", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    else passed++;
    stayed_idle = idle_ok;
    repeat (20) begin @(negedge clk); if (tx_busy !== 1'b0) stayed_idle = 1'b0; end
    checks++;
    if (!stayed_idle || done_cnt - d0 !== 1)
      $display("FAIL b2b_ignored got idle=%0d done=%0d want 1 1", stayed_idle, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [10:0] bits; bit ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'hED);
    device(1'b1, 6, 0, bits, ok);
    checks++;
    if (!ok || rst_busy !== 1'b0 || rst_oe !== 2'b00)
      $display("FAIL rstmid_release got ok=%0d busy=%b oe=%b want 1 0 00", ok, rst_busy, rst_oe);
    else passed++;
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || tx_busy !== 1'b0)
      $display("FAIL rstmid_quiet got done=%0d err=%0d busy=%b want 0 0 0",
               done_cnt - d0, err_cnt - e0, tx_busy);
    else passed++;
    send_check("after_rst", 8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0});
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_seen !== 1'b0) $display("FAIL done_err_overlap got 1 want 0");
    else passed++;
  endtask

  initial begin
    test_reset;
    test_send;
    test_parity;
    test_nack;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_exclusive;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
